adc_frame_tx: RTL
=================

# adc_frame_tx

Bit-serial ADC LVDS link emulator: generates the frame line and `Lanes` data lines of a one-wire-per-lane ADC interface, MSB first, one bit per `TxClk` cycle. It drives the ADC receive/frame-alignment path in loopback and simulation, standing in for a real converter. A programmable start phase deliberately misaligns the word boundary so that receiver bitslip alignment can be exercised. Data comes from a valid/ready word interface or from internal test generators.

## Interface

Parameters:
- `AdcBits`, 14, word width; legal values 8, 10, 12, 14.
- `Lanes`, 2, number of data lines.
- `FrmPattern`, 16'b0011111110000000, frame word; bits `[AdcBits-1:0]` are used.

Ports:
- `TxClk`  in  1  bit-rate clock; every register is clocked on its rising edge.
- `TxRst`  in  1  asynchronous, active-high reset.
- `TxEn`  in  1  level; starts and stops transmission.
- `TxPhase`  in  4  start offset in bits; sampled on the IDLE→RUN edge.
- `TxMode`  in  2  source select: 00 user data, 01 ramp, 10 `TestWord`, 11 `FrmPattern` on all data lanes.
- `TestWord`  in  AdcBits  fixed word used in mode 10.
- `DinData`  in  Lanes*AdcBits  user words; lane i occupies `[i*AdcBits +: AdcBits]`.
- `DinValid`  in  1  `DinData` is valid.
- `DinReady`  out  1  word is accepted this cycle (combinational).
- `FrmOut`  out  1  serial frame line.
- `DatOut`  out  Lanes  serial data lines.
- `WordStrobe`  out  1  one-cycle pulse while the first bit (MSB) of a word is on the outputs.
- `Underrun`  out  1  sticky flag: a user word was missing at a reload.

## Operation

- States: IDLE and RUN. Reset puts the block in IDLE and clears every register, so all outputs read 0.
- In IDLE: `FrmOut`, `DatOut` and `WordStrobe` are 0 and `BitCnt` is 0.
- IDLE→RUN happens on the first edge where `TxEn`=1. On that edge:
  - `p` = `TxPhase`, or 0 if `TxPhase` ≥ `AdcBits`.
  - `BitCnt` ← `p`.
  - Frame shift register ← `FrmPattern[AdcBits-1:0]` shifted left by `p`, zero-filled.
  - Data shift registers ← 0.
  - `Underrun` ← 0.
  - The first word is therefore truncated by `p` bits.
- Each edge in RUN, when `BitCnt` < `AdcBits-1`: `BitCnt` increments and every shift register shifts left by one.
- Each edge in RUN, when `BitCnt` = `AdcBits-1` (the reload edge):
  - `BitCnt` ← 0 and the frame register ← `FrmPattern`.
  - Each data register ← its next source word.
  - `WordStrobe` ← 1; it is 0 on all other edges.
- Output mapping: `FrmOut` = frame register MSB; `DatOut[i]` = lane i register MSB. All outputs are driven straight from registers.
- Source words, resolved at the reload edge using the current `TxMode`:
  - 00: `DinReady` = RUN & (`BitCnt`=`AdcBits-1`) & `TxEn`. If `DinValid`, load `DinData`. Otherwise load 0 and set `Underrun`.
  - 01: lane i ← (`RampCnt` + i) mod 2^`AdcBits`; then `RampCnt` increments, wrapping at 2^`AdcBits`. `RampCnt` holds its value across mode changes and resets only on `TxRst`.
  - 10: every lane ← `TestWord`.
  - 11: every lane ← `FrmPattern[AdcBits-1:0]`.
  - In every mode other than 00, `DinReady` = 0.
- Stop: `TxEn`=0 on a reload edge moves the block to IDLE instead of loading a word. The outputs read 0 from the next cycle, so a word in flight always completes. `TxEn`=0 on any other edge has no effect.
- Mode and `TxPhase` changes in RUN: `TxMode` takes effect at the next reload edge. `TxPhase` is ignored until the next IDLE→RUN edge.
- `Underrun` stays set until reset or the next IDLE→RUN edge.
- Reset asserted mid-word: immediate return to IDLE with all outputs 0. After reset is released, `RampCnt` restarts from 0.

## Timing

- Word period is exactly `AdcBits` cycles. `WordStrobe` has period `AdcBits` in RUN.
- Latency: a word loaded on a reload edge shows its MSB on `DatOut` in the cycle after that edge, coincident with `WordStrobe`=1 and with `FrmOut` = `FrmPattern[AdcBits-1]`. Its LSB appears `AdcBits-1` cycles later.
- With `p` = 0, the first bits reach the outputs one cycle after the IDLE→RUN edge. The first reload comes `AdcBits-p` edges after entry.
- A handshake transfer happens in the single cycle where `DinValid`=1 and `DinReady`=1. `DinValid` asserted outside that window has no effect.

## Test plan

- Frame pattern, `AdcBits`=14, `TxPhase`=0, mode 10, `TestWord`=14'h2A5F → `FrmOut` repeats seven 1s then seven 0s. `DatOut[0]` serialises 10101001011111 MSB first. `WordStrobe` pulses every 14 cycles, aligned to the first 1 of `FrmOut`.
- Phase offset, `TxPhase`=5 → the first `FrmOut` run is two 1s then seven 0s, after which the nominal pattern follows. `TxPhase`=15 behaves exactly like `TxPhase`=0.
- Ramp, mode 01, `Lanes`=2 → lane 0 carries 0,1,2,…, lane 1 carries 1,2,3,…. The sequence wraps 16383→0 (and lane 1 16383→0 one word earlier).
- User data → `DinReady` pulses once per 14 cycles and words stream back to back. Withholding `DinValid` for one reload → that word is all zeros and `Underrun`=1. `Underrun` clears on the next IDLE→RUN edge.
- Stop/reset → `TxEn` dropped mid-word: the word finishes, then outputs go to 0 and state is IDLE. `TxRst` pulsed mid-word: outputs are 0 immediately, and restarting in ramp mode begins at 0.
- Loopback with the frame-alignment receiver for each of `AdcBits` = 8, 10, 12, 14 and every `TxPhase` value → the receiver reports alignment done, and recovered data equals the transmitted ramp.

Source files
------------

// File: rtl/adc_frame_tx.sv
// Bit-serial ADC LVDS link emulator: one frame line plus Lanes data lines, MSB first, with a
// programmable start phase that misaligns the first word for receiver bitslip exercise.
module adc_frame_tx #(
    parameter int unsigned AdcBits    = 14,
    parameter int unsigned Lanes      = 2,
    parameter logic [15:0] FrmPattern = 16'b0011111110000000
) (
    input  logic                     TxClk,
    input  logic                     TxRst,
    input  logic                     TxEn,
    input  logic [3:0]               TxPhase,
    input  logic [1:0]               TxMode,
    input  logic [AdcBits-1:0]       TestWord,
    input  logic [Lanes*AdcBits-1:0] DinData,
    input  logic                     DinValid,
    output logic                     DinReady,
    output logic                     FrmOut,
    output logic [Lanes-1:0]         DatOut,
    output logic                     WordStrobe,
    output logic                     Underrun
);
    localparam logic [AdcBits-1:0] FrmWord   = FrmPattern[AdcBits-1:0];
    localparam logic [3:0]         LastBit   = 4'(AdcBits - 1);
    localparam logic [1:0]         ModeUser  = 2'b00;
    localparam logic [1:0]         ModeRamp  = 2'b01;
    localparam logic [1:0]         ModeTest  = 2'b10;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                        r_state;
    logic [3:0]                    r_bit_cnt;
    logic [AdcBits-1:0]            r_frm_sr;
    logic [Lanes-1:0][AdcBits-1:0] r_dat_sr;
    logic [AdcBits-1:0]            r_ramp_cnt;
    logic                          r_strobe;
    logic                          r_underrun;

    logic                          w_reload;
    logic [3:0]                    w_phase;
    logic [Lanes-1:0][AdcBits-1:0] w_src;
    logic                          w_missing;

    assign w_reload = (r_state == StRun) && (r_bit_cnt == LastBit);
    // Out-of-range phases fall back to an aligned start.
    assign w_phase  = (TxPhase <= LastBit) ? TxPhase : 4'd0;
    assign DinReady = w_reload && TxEn && (TxMode == ModeUser);

    always_comb begin
        w_src     = '0;
        w_missing = 1'b0;
        case (TxMode)
            ModeUser: begin
                if (DinValid) begin
                    w_src = DinData;
                end else begin
                    w_missing = 1'b1;
                end
            end
            ModeRamp: begin
                for (int i = 0; i < Lanes; i++) begin
                    w_src[i] = r_ramp_cnt + AdcBits'(i);
                end
            end
            ModeTest: begin
                for (int i = 0; i < Lanes; i++) begin
                    w_src[i] = TestWord;
                end
            end
            default: begin
                for (int i = 0; i < Lanes; i++) begin
                    w_src[i] = FrmWord;
                end
            end
        endcase
    end

    always_ff @(posedge TxClk or posedge TxRst) begin
        if (TxRst) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_frm_sr   <= '0;
            r_dat_sr   <= '0;
            r_ramp_cnt <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_strobe <= 1'b0;
                    if (TxEn) begin
                        r_state    <= StRun;
                        r_bit_cnt  <= w_phase;
                        r_frm_sr   <= FrmWord << w_phase;
                        r_dat_sr   <= '0;
                        r_underrun <= 1'b0;
                    end
                end
                StRun: begin
                    if (r_bit_cnt < LastBit) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_frm_sr  <= r_frm_sr << 1;
                        for (int i = 0; i < Lanes; i++) begin
                            r_dat_sr[i] <= r_dat_sr[i] << 1;
                        end
                        r_strobe  <= 1'b0;
                    end else if (!TxEn) begin
                        // Stop only at a word boundary so the last word always completes.
                        r_state   <= StIdle;
                        r_bit_cnt <= '0;
                        r_frm_sr  <= '0;
                        r_dat_sr  <= '0;
                        r_strobe  <= 1'b0;
                    end else begin
                        r_bit_cnt <= '0;
                        r_frm_sr  <= FrmWord;
                        r_dat_sr  <= w_src;
                        r_strobe  <= 1'b1;
                        if (w_missing) begin
                            r_underrun <= 1'b1;
                        end
                        if (TxMode == ModeRamp) begin
                            r_ramp_cnt <= r_ramp_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign FrmOut     = r_frm_sr[AdcBits-1];
    assign WordStrobe = r_strobe;
    assign Underrun   = r_underrun;

    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        assign DatOut[g] = r_dat_sr[g][AdcBits-1];
    end

endmodule
